// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment codes and scan state type shared by the display blocks
package seg7_pkg;

  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_OFF  = 8'h00;

  // Entry n is the g..a pattern for hex digit n; bit 7 (dp) is always clear here.
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h71, 8'h79, 8'h5e, 8'h39, 8'h7c, 8'h77, 8'h6f, 8'h7f,
    8'h07, 8'h7d, 8'h6d, 8'h66, 8'h4f, 8'h5b, 8'h06, 8'h3f
  };

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_t;

endpackage

// File: rtl/seg7_scan_display_if.sv
// rtl/seg7_scan_display_if.sv - digit data inputs and multiplexed select/segment pins
interface seg7_scan_display_if #(
  parameter int NUM_DIGITS = 4
);

  logic                      en;
  logic [4*NUM_DIGITS-1:0]   digits;
  logic [NUM_DIGITS-1:0]     dp;
  logic [NUM_DIGITS-1:0]     blank;
  logic                      mask;
  logic [NUM_DIGITS-1:0]     blink;
  logic [NUM_DIGITS-1:0]     digit_sel_n;
  logic [7:0]                segs;
  logic                      frame_start;

  modport master (
    output en, digits, dp, blank, mask, blink,
    input  digit_sel_n, segs, frame_start
  );

  modport slave (
    input  en, digits, dp, blank, mask, blink,
    output digit_sel_n, segs, frame_start
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - nibble/dp/mask to active-high segment pattern
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       mask,
  output logic [7:0] segs
);

  always_comb begin
    segs    = mask ? SEG_DASH : SEG_LUT[nibble];
    segs[7] = dp;
  end

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - N-digit scanned 7-segment driver; SEG7_SCAN_BLINK_EN adds per-digit blink
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 125000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_display_if.slave bus
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int PW = $clog2(NUM_DIGITS);
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  scan_state_t                state, state_next;
  logic [CW-1:0]              cnt, cnt_next;
  logic [PW-1:0]              pos, pos_next;
  logic [BW-1:0]              blank_cnt, blank_cnt_next;
  logic                       load_pending;
  logic                       tick, wrap, load, dark;

  logic [NUM_DIGITS-1:0][3:0] sh_digits;
  logic [NUM_DIGITS-1:0]      sh_dp, sh_blank;
  logic                       sh_mask;

  logic [NUM_DIGITS-1:0]      sel_next;
  logic [7:0]                 dec_segs, segs_next;

  seg7_hex_decode u_dec (
    .nibble (sh_digits[pos]),
    .dp     (sh_dp[pos]),
    .mask   (sh_mask),
    .segs   (dec_segs)
  );

`ifdef SEG7_SCAN_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [FW-1:0]         frame_cnt;
  logic                  blink_phase;
  logic [NUM_DIGITS-1:0] sh_blink;

  // frame_cnt counts loads since the last toggle, so each phase lasts BLINK_FRAMES whole frames
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      sh_blink    <= '0;
    end else if (load) begin
      sh_blink <= bus.blink;
      if (frame_cnt == FW'(BLINK_FRAMES)) begin
        frame_cnt   <= FW'(1);
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  assign dark = sh_blank[pos] || (blink_phase && sh_blink[pos]);
`else
  logic unused_ok;
  assign unused_ok = ^{bus.blink, BLINK_FRAMES[0]};
  assign dark      = sh_blank[pos];
`endif

  always_comb begin
    tick           = bus.en && (cnt == CW'(CLK_DIV - 1));
    wrap           = (pos == PW'(NUM_DIGITS - 1));
    load           = bus.en && (load_pending || (tick && wrap));
    cnt_next       = cnt;
    pos_next       = pos;
    state_next     = state;
    blank_cnt_next = blank_cnt;

    if (!bus.en) begin
      state_next     = BLANK;
      blank_cnt_next = '0;
    end else if (tick) begin
      cnt_next       = '0;
      pos_next       = wrap ? '0 : pos + PW'(1);
      state_next     = BLANK;
      blank_cnt_next = '0;
    end else begin
      cnt_next = cnt + CW'(1);
      if (state == BLANK) begin
        if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
          state_next = SHOW;
        end else begin
          blank_cnt_next = blank_cnt + BW'(1);
        end
      end
    end

    sel_next  = '1;
    segs_next = SEG_OFF;
    if (bus.en && (state == SHOW) && !dark) begin
      sel_next[pos] = 1'b0;
      segs_next     = dec_segs;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= BLANK;
      cnt             <= '0;
      pos             <= '0;
      blank_cnt       <= '0;
      load_pending    <= 1'b1;
      bus.digit_sel_n <= '1;
      bus.segs        <= SEG_OFF;
      bus.frame_start <= 1'b0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      pos             <= pos_next;
      blank_cnt       <= blank_cnt_next;
      bus.digit_sel_n <= sel_next;
      bus.segs        <= segs_next;
      bus.frame_start <= load;
      if (load) begin
        load_pending <= 1'b0;
      end
    end
  end

  // Shadows only change on a frame boundary so a frame never mixes old and new data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      sh_mask   <= 1'b0;
    end else if (load) begin
      sh_digits <= bus.digits;
      sh_dp     <= bus.dp;
      sh_blank  <= bus.blank;
      sh_mask   <= bus.mask;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - randomized and directed bench for seg7_scan_display
module tb_seg7_scan_display;

  localparam int N   = 4;
  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int BF  = 2;
`ifdef SEG7_SCAN_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_display_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_display #(
    .NUM_DIGITS  (N),
    .CLK_DIV     (DIV),
    .BLANK_CYCLES(BLK),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit inv_on   = 1'b0;

  // Reference model: slot position and dark count tracked as plain integers
  int   lut [16] = '{'h3f, 'h06, 'h5b, 'h4f, 'h66, 'h6d, 'h7d, 'h07,
                     'h7f, 'h6f, 'h77, 'h7c, 'h39, 'h5e, 'h79, 'h71};
  int   m_cnt, m_pos, m_dark, m_frame;
  bit   m_pending, m_phase;
  int   s_dig [N];
  bit   s_dp [N], s_blank [N], s_blink [N];
  bit   s_mask;
  logic [N-1:0] exp_sel  = '1;
  logic [7:0]   exp_segs = 8'h00;
  logic         exp_fs   = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_pos = 0; m_dark = BLK; m_pending = 1; m_frame = 0; m_phase = 0;
      exp_sel = '1; exp_segs = 8'h00; exp_fs = 1'b0;
    end else if (!bus.en) begin
      m_dark = BLK; exp_sel = '1; exp_segs = 8'h00; exp_fs = 1'b0;
    end else begin
      bit lit;
      lit = (m_dark == 0) && !s_blank[m_pos] && !(BLINK_ON && m_phase && s_blink[m_pos]);
      exp_sel  = '1;
      exp_segs = 8'h00;
      if (lit) begin
        exp_sel[m_pos] = 1'b0;
        exp_segs = (s_mask ? 8'h40 : 8'(lut[s_dig[m_pos]])) | (s_dp[m_pos] ? 8'h80 : 8'h00);
      end
      exp_fs = m_pending || (m_cnt == DIV - 1 && m_pos == N - 1);
      if (exp_fs) begin
        for (int i = 0; i < N; i++) begin
          s_dig[i]   = int'(bus.digits[4*i +: 4]);
          s_dp[i]    = bus.dp[i];
          s_blank[i] = bus.blank[i];
          s_blink[i] = bus.blink[i];
        end
        s_mask    = bus.mask;
        m_phase   = ((m_frame / BF) % 2) == 1;
        m_frame   = m_frame + 1;
        m_pending = 0;
      end
      if (m_dark > 0) m_dark = m_dark - 1;
      if (m_cnt == DIV - 1) begin
        m_cnt = 0; m_pos = (m_pos + 1) % N; m_dark = BLK;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (inv_on) begin
      checks++;
      if ($countones(~bus.digit_sel_n) > 1) begin
        failures++;
        $display("FAIL one_hot_sel t=%0t got=%b want=at most one low", $time, bus.digit_sel_n);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.en = 1'b0; bus.digits = '0; bus.dp = '0;
    bus.blank = '0; bus.mask = 1'b0; bus.blink = '0;
    repeat (3) cycle();
    checks++;
    if (bus.digit_sel_n !== 4'hF || bus.segs !== 8'h00 || bus.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got sel=%b segs=%h fs=%b want sel=1111 segs=00 fs=0",
               bus.digit_sel_n, bus.segs, bus.frame_start);
    end
    rst_n = 1'b1;
    repeat (3) cycle();
    checks++;
    if (bus.digit_sel_n !== 4'hF || bus.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL idle_disabled got sel=%b fs=%b want sel=1111 fs=0", bus.digit_sel_n, bus.frame_start);
    end
    inv_on = 1'b1;
  endtask

  task automatic test_scan();
    bus.digits = 16'h4321;
    bus.en     = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      checks++;
      if (bus.digit_sel_n !== exp_sel || bus.segs !== exp_segs || bus.frame_start !== exp_fs) begin
        failures++;
        $display("FAIL scan_model cyc=%0d got sel=%b segs=%h fs=%b want sel=%b segs=%h fs=%b",
                 i, bus.digit_sel_n, bus.segs, bus.frame_start, exp_sel, exp_segs, exp_fs);
      end
      if (i == 1 || i == 32) begin
        checks++;
        if (bus.frame_start !== 1'b1) begin
          failures++;
          $display("FAIL scan_frame_start cyc=%0d got=%b want=1", i, bus.frame_start);
        end
      end
      if (i <= 2 || i == 9 || i == 10) begin
        checks++;
        if (bus.digit_sel_n !== 4'hF || bus.segs !== 8'h00) begin
          failures++;
          $display("FAIL scan_dark cyc=%0d got sel=%b segs=%h want sel=1111 segs=00", i, bus.digit_sel_n, bus.segs);
        end
      end
      if ((i >= 3 && i <= 8) || (i >= 11 && i <= 16)) begin
        checks++;
        if (bus.digit_sel_n !== ((i <= 8) ? 4'b1110 : 4'b1101) ||
            bus.segs !== ((i <= 8) ? 8'h06 : 8'h5b)) begin
          failures++;
          $display("FAIL scan_digit cyc=%0d got sel=%b segs=%h want sel=%b segs=%h", i, bus.digit_sel_n,
                   bus.segs, (i <= 8) ? 4'b1110 : 4'b1101, (i <= 8) ? 8'h06 : 8'h5b);
        end
      end
    end
  endtask

  task automatic test_midframe();
    int pre71 = 0;
    int post71 = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 48; i++) begin
      if (i == 4) bus.digits = 16'hFFFF;
      cycle();
      checks++;
      if (bus.digit_sel_n !== exp_sel || bus.segs !== exp_segs || bus.frame_start !== exp_fs) begin
        failures++;
        $display("FAIL midframe_model i=%0d got sel=%b segs=%h fs=%b want sel=%b segs=%h fs=%b",
                 i, bus.digit_sel_n, bus.segs, bus.frame_start, exp_sel, exp_segs, exp_fs);
      end
      if (exp_fs) seen = 1'b1;
      if (bus.segs === 8'h71) begin
        if (seen) post71++;
        else pre71++;
      end
    end
    checks++;
    if (pre71 !== 0 || post71 !== 18) begin
      failures++;
      $display("FAIL midframe_tearing got pre=%0d post=%0d want pre=0 post=18", pre71, post71);
    end
  endtask

  task automatic test_mask_blank();
    int c0_seen = 0;
    logic [7:0] want;
    bus.mask = 1'b1; bus.dp = 4'b0100; bus.blank = 4'b0001; bus.digits = 16'($urandom);
    for (int i = 0; i < 64; i++) begin
      cycle();
      checks++;
      if (bus.digit_sel_n !== exp_sel || bus.segs !== exp_segs || bus.frame_start !== exp_fs) begin
        failures++;
        $display("FAIL mask_model i=%0d got sel=%b segs=%h fs=%b want sel=%b segs=%h fs=%b",
                 i, bus.digit_sel_n, bus.segs, bus.frame_start, exp_sel, exp_segs, exp_fs);
      end
      if (i >= 8 && bus.digit_sel_n !== 4'hF) begin
        checks++;
        want = (bus.digit_sel_n === 4'b1011) ? 8'hC0 : 8'h40;
        if (bus.digit_sel_n === 4'b1110 || bus.segs !== want) begin
          failures++;
          $display("FAIL mask_segs i=%0d got sel=%b segs=%h want digit0 dark segs=%h", i, bus.digit_sel_n, bus.segs, want);
        end
        if (bus.segs === 8'hC0) c0_seen++;
      end
    end
    checks++;
    if (c0_seen == 0) begin
      failures++;
      $display("FAIL mask_dp_seen got=%0d want=nonzero", c0_seen);
    end
  endtask

  task automatic test_enable();
    logic [3:0] prev;
    logic [3:0] held;
    bit found = 1'b0;
    bus.mask = 1'b0; bus.blank = '0; bus.dp = 4'($urandom); bus.digits = 16'($urandom);
    prev = bus.digit_sel_n;
    for (int g = 0; g < 64; g++) begin
      cycle();
      if (prev === 4'hF && bus.digit_sel_n !== 4'hF) begin
        found = 1'b1;
        break;
      end
      prev = bus.digit_sel_n;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL enable_find_lit got=timeout want=lit digit within 64 cycles");
    end
    held   = bus.digit_sel_n;
    bus.en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (bus.digit_sel_n !== 4'hF || bus.segs !== 8'h00 || exp_sel !== 4'hF) begin
        failures++;
        $display("FAIL enable_off_dark i=%0d got sel=%b segs=%h want sel=1111 segs=00", i, bus.digit_sel_n, bus.segs);
      end
    end
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (bus.digit_sel_n !== ((i < 2) ? 4'hF : held) || bus.digit_sel_n !== exp_sel || bus.segs !== exp_segs) begin
        failures++;
        $display("FAIL enable_resume i=%0d got sel=%b segs=%h want sel=%b segs=%h", i, bus.digit_sel_n, bus.segs,
                 (i < 2) ? 4'hF : held, exp_segs);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) begin
        bus.digits = 16'($urandom); bus.dp = 4'($urandom); bus.blank = 4'($urandom);
        bus.mask = ($urandom_range(3) == 0); bus.blink = 4'($urandom);
      end
      if ($urandom_range(31) == 0) bus.en = ~bus.en;
      cycle();
      checks++;
      if (bus.digit_sel_n !== exp_sel || bus.segs !== exp_segs || bus.frame_start !== exp_fs) begin
        failures++;
        $display("FAIL random_model i=%0d got sel=%b segs=%h fs=%b want sel=%b segs=%h fs=%b",
                 i, bus.digit_sel_n, bus.segs, bus.frame_start, exp_sel, exp_segs, exp_fs);
      end
    end
    bus.en = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    for (int g = 0; g < 64 && !found; g++) begin
      cycle();
      if (bus.digit_sel_n !== 4'hF) found = 1'b1;
    end
    bus.blank = '0; bus.mask = 1'b0; bus.blink = '0;
    rst_n = 1'b0;
    cycle();
    checks++;
    if (!found || bus.digit_sel_n !== 4'hF || bus.segs !== 8'h00 || bus.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got lit_found=%0d sel=%b segs=%h fs=%b want 1 1111 00 0",
               found, bus.digit_sel_n, bus.segs, bus.frame_start);
    end
    rst_n = 1'b1;
    cycle();
    checks++;
    if (bus.frame_start !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_reload got fs=%b want=1", bus.frame_start);
    end
    found = 1'b0;
    for (int g = 0; g < 40 && !found; g++) begin
      cycle();
      if (bus.digit_sel_n !== 4'hF) found = 1'b1;
    end
    checks++;
    if (bus.digit_sel_n !== 4'b1110) begin
      failures++;
      $display("FAIL reset_mid_pos0 got sel=%b want=1110", bus.digit_sel_n);
    end
  endtask

  task automatic test_blink();
    int frame = -1;
    bit sh1 [6];
    bit sh2 [6];
    rst_n = 1'b0; bus.en = 1'b0; bus.blink = 4'b0010; bus.blank = '0; bus.mask = 1'b0;
    bus.digits = 16'($urandom); bus.dp = 4'($urandom);
    repeat (2) cycle();
    rst_n = 1'b1; bus.en = 1'b1;
    for (int i = 0; i < 6 * N * DIV; i++) begin
      cycle();
      checks++;
      if (bus.digit_sel_n !== exp_sel || bus.segs !== exp_segs || bus.frame_start !== exp_fs) begin
        failures++;
        $display("FAIL blink_model i=%0d got sel=%b segs=%h fs=%b want sel=%b segs=%h fs=%b",
                 i, bus.digit_sel_n, bus.segs, bus.frame_start, exp_sel, exp_segs, exp_fs);
      end
      if (exp_fs) frame++;
      if (frame >= 0 && frame < 6) begin
        if (bus.digit_sel_n === 4'b1101) sh1[frame] = 1'b1;
        if (bus.digit_sel_n === 4'b1011) sh2[frame] = 1'b1;
      end
    end
    for (int f = 0; f < 6; f++) begin
      checks++;
      if (sh1[f] !== (BLINK_ON ? ((f / BF) % 2 == 0) : 1'b1) || sh2[f] !== 1'b1) begin
        failures++;
        $display("FAIL blink_frame f=%0d got d1=%b d2=%b want d1=%b d2=1", f, sh1[f], sh2[f],
                 BLINK_ON ? ((f / BF) % 2 == 0) : 1'b1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe();
    test_mask_blank();
    test_enable();
    test_random();
    test_reset_mid();
    test_blink();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
